// File: rtl/tof_i2c_pkg.sv
// Shared types and constants for the ToF I2C register target.
// Macro TOF_TGT_AUTOINC_EN selects pointer auto-increment after each data byte.
package tof_i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEVADDR,
      ST_ACK_DEV,
      ST_PTR_HI,
      ST_ACK_HI,
      ST_PTR_LO,
      ST_ACK_LO,
      ST_WR_DATA,
      ST_ACK_WR,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_t;

   localparam logic [6:0]  DEF_DEV_ADDR = 7'h29;
   localparam logic        SDA_ACK      = 1'b0;
   localparam logic        SDA_NACK     = 1'b1;
   localparam int unsigned BIT_W        = 3;
   localparam int unsigned PTR_W        = 16;

   // Pointer value used for the next data byte of the same transaction.
   function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] p);
`ifdef TOF_TGT_AUTOINC_EN
      return p + PTR_W'(1);
`else
      return p;
`endif
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA pad synchronisers with SCL edge and START/STOP condition detection.
module i2c_bus_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_c,
   output logic scl_rise_c,
   output logic scl_fall_c,
   output logic start_c,
   output logic stop_c
);

   logic [1:0] scl_ff;
   logic [1:0] sda_ff;
   logic       scl_q;
   logic       sda_q;

   // Idle bus level is high, so everything resets to 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_ff <= 2'b11;
         sda_ff <= 2'b11;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[0], scl_i};
         sda_ff <= {sda_ff[0], sda_i};
         scl_q  <= scl_ff[1];
         sda_q  <= sda_ff[1];
      end
   end

   assign sda_c      = sda_ff[1];
   assign scl_rise_c = scl_ff[1] & ~scl_q;
   assign scl_fall_c = ~scl_ff[1] & scl_q;
   assign start_c    = scl_ff[1] & scl_q & sda_q & ~sda_ff[1];
   assign stop_c     = scl_ff[1] & scl_q & ~sda_q & sda_ff[1];

endmodule

// File: rtl/tof_i2c_target.sv
// I2C target exposing a 2^REG_AW byte register file behind a 16-bit pointer.
// Pointer auto-increment is enabled by defining TOF_TGT_AUTOINC_EN.
module tof_i2c_target
   import tof_i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
   parameter int unsigned REG_AW   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   input  logic              lw_en,
   input  logic [REG_AW-1:0] lw_addr,
   input  logic [7:0]        lw_data,
   output logic              wr_strobe,
   output logic [PTR_W-1:0]  wr_addr,
   output logic [7:0]        wr_data,
   output logic              rd_strobe,
   output logic              busy
);

   localparam int unsigned REG_N = 1 << REG_AW;

   logic             sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;
   state_t           state;
   logic [BIT_W-1:0] bit_cnt;
   logic [6:0]       rx_sr;
   logic [6:0]       tx_sr;
   logic [PTR_W-1:0] ptr;
   logic             rnw;
   logic             ack_phase;
   logic             m_ack;
   logic [7:0]       regfile [REG_N];

   logic [7:0]       rx_byte_c;
   logic             byte_done_c;
   logic             wr_fire_c;
   logic [PTR_W-1:0] ptr_nx_c;
   logic [7:0]       rd_cur_c;
   logic [7:0]       rd_nxt_c;

   i2c_bus_sync u_sync (
      .clk        (clk),
      .reset      (reset),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_c      (sda_c),
      .scl_rise_c (scl_rise_c),
      .scl_fall_c (scl_fall_c),
      .start_c    (start_c),
      .stop_c     (stop_c)
   );

   assign rx_byte_c   = {rx_sr, sda_c};
   assign byte_done_c = scl_rise_c & (bit_cnt == BIT_W'(7));
   assign wr_fire_c   = (state == ST_WR_DATA) & byte_done_c & ~start_c & ~stop_c;
   assign ptr_nx_c    = ptr_advance(ptr);
   assign rd_cur_c    = regfile[ptr[REG_AW-1:0]];
   assign rd_nxt_c    = regfile[ptr_nx_c[REG_AW-1:0]];

   // Register file: no reset; the I2C write takes priority over the local port.
   always_ff @(posedge clk) begin
      if (wr_fire_c) begin
         regfile[ptr[REG_AW-1:0]] <= rx_byte_c;
      end else if (lw_en) begin
         regfile[lw_addr] <= lw_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         ptr       <= '0;
         rnw       <= 1'b0;
         ack_phase <= 1'b0;
         m_ack     <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_strobe <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         if (stop_c) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else if (start_c) begin
            state     <= ST_DEVADDR;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
         end else begin
            case (state)
               ST_DEVADDR, ST_PTR_HI, ST_PTR_LO, ST_WR_DATA: begin
                  if (scl_rise_c) begin
                     rx_sr   <= rx_byte_c[6:0];
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
                  if (byte_done_c) begin
                     if (state == ST_DEVADDR) begin
                        if (rx_byte_c[7:1] == DEV_ADDR) begin
                           busy  <= 1'b1;
                           rnw   <= rx_byte_c[0];
                           state <= ST_ACK_DEV;
                        end else begin
                           busy  <= 1'b0;
                           state <= ST_WAIT_STOP;
                        end
                     end else if (state == ST_PTR_HI) begin
                        ptr[15:8] <= rx_byte_c;
                        state     <= ST_ACK_HI;
                     end else if (state == ST_PTR_LO) begin
                        ptr[7:0] <= rx_byte_c;
                        state    <= ST_ACK_LO;
                     end else begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= rx_byte_c;
                        ptr       <= ptr_nx_c;
                        state     <= ST_ACK_WR;
                     end
                  end
               end
               // Drive ACK on the 8th SCL fall, release (or start reading) on the 9th.
               ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: begin
                  if (scl_fall_c) begin
                     if (!ack_phase) begin
                        sda_oe    <= ~SDA_ACK;
                        ack_phase <= 1'b1;
                     end else begin
                        ack_phase <= 1'b0;
                        sda_oe    <= 1'b0;
                        if (state == ST_ACK_DEV && rnw) begin
                           tx_sr     <= rd_cur_c[6:0];
                           sda_oe    <= ~rd_cur_c[7];
                           rd_strobe <= 1'b1;
                           state     <= ST_RD_DATA;
                        end else if (state == ST_ACK_DEV) begin
                           state <= ST_PTR_HI;
                        end else if (state == ST_ACK_HI) begin
                           state <= ST_PTR_LO;
                        end else begin
                           state <= ST_WR_DATA;
                        end
                     end
                  end
               end
               ST_RD_DATA: begin
                  if (scl_rise_c) begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     if (bit_cnt == BIT_W'(7)) begin
                        ack_phase <= 1'b0;
                        state     <= ST_RD_ACK;
                     end
                  end else if (scl_fall_c) begin
                     sda_oe <= ~tx_sr[6];
                     tx_sr  <= {tx_sr[5:0], 1'b0};
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise_c && ack_phase) begin
                     m_ack <= (sda_c == SDA_ACK);
                  end
                  if (scl_fall_c) begin
                     if (!ack_phase) begin
                        sda_oe    <= 1'b0;
                        ack_phase <= 1'b1;
                     end else if (m_ack) begin
                        ack_phase <= 1'b0;
                        ptr       <= ptr_nx_c;
                        tx_sr     <= rd_nxt_c[6:0];
                        sda_oe    <= ~rd_nxt_c[7];
                        rd_strobe <= 1'b1;
                        state     <= ST_RD_DATA;
                     end else begin
                        ack_phase <= 1'b0;
                        sda_oe    <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_WAIT_STOP;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tof_i2c_target.sv
// Directed bench for tof_i2c_target; expectations follow TOF_TGT_AUTOINC_EN.
module tb_tof_i2c_target;
   import tof_i2c_pkg::*;

   localparam int Q = 5;
`ifdef TOF_TGT_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic        lw_en = 1'b0;
   logic [7:0]  lw_addr = 8'h00;
   logic [7:0]  lw_data = 8'h00;
   logic        sda_oe, wr_strobe, rd_strobe, busy;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   wire         sda_bus = sda_m & ~sda_oe;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   logic [15:0] wa_q[$];
   logic [7:0]  wd_q[$];

   always #5 clk = ~clk;

   tof_i2c_target dut (
      .clk       (clk),
      .reset     (reset),
      .scl_i     (scl),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .lw_en     (lw_en),
      .lw_addr   (lw_addr),
      .lw_data   (lw_data),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_strobe (rd_strobe),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (!reset) begin
         if (wr_strobe) begin
            wr_cnt++;
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
         end
         if (rd_strobe) rd_cnt++;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation still running");
      $fatal(1);
   end

   task automatic wq();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      wr_cnt = 0;
      rd_cnt = 0;
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic local_wr(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      lw_addr = a; lw_data = d; lw_en = 1'b1;
      @(posedge clk); #1;
      lw_en = 1'b0;
   endtask

   task automatic i2c_start();
      if (scl == 1'b0) begin
         wq(); sda_m = 1'b1; wq(); scl = 1'b1; wq();
      end
      sda_m = 1'b0; wq(); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wq(); sda_m = 1'b0; wq(); scl = 1'b1; wq(); sda_m = 1'b1; wq();
   endtask

   task automatic send_bit(input logic b);
      wq(); sda_m = b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0;
   endtask

   // With collide set, lw_en is held through the last bit until wr_strobe shows.
   task automatic send_byte(input logic [7:0] b, input bit collide, output logic acked, output logic oe9);
      for (int i = 7; i >= 0; i--) begin
         if (collide && i == 0) begin
            wq(); sda_m = b[i]; lw_en = 1'b1; wq(); scl = 1'b1;
            for (int c = 0; c < 2 * Q; c++) begin
               @(posedge clk); #1;
               if (wr_strobe) lw_en = 1'b0;
            end
            lw_en = 1'b0; scl = 1'b0;
         end else begin
            send_bit(b[i]);
         end
      end
      wq(); sda_m = 1'b1; wq(); scl = 1'b1; wq();
      acked = (sda_bus == 1'b0);
      oe9 = sda_oe;
      wq(); scl = 1'b0;
   endtask

   task automatic read_byte(input bit ack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         wq(); sda_m = 1'b1; wq(); scl = 1'b1; wq();
         d[i] = sda_bus;
         wq(); scl = 1'b0;
      end
      wq(); sda_m = ack ? 1'b0 : 1'b1; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0;
   endtask

   // START, address 0x29 write, 16-bit pointer; returns number of ACKs seen.
   task automatic wr_hdr(input logic [15:0] p, output int acks);
      logic a, o;
      acks = 0;
      i2c_start();
      send_byte(8'h52, 1'b0, a, o); acks += int'(a);
      send_byte(p[15:8], 1'b0, a, o); acks += int'(a);
      send_byte(p[7:0], 1'b0, a, o); acks += int'(a);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
      checks++; if (rd_strobe !== 1'b0) begin errors++; $display("FAIL reset_rd_strobe: got %b want 0", rd_strobe); end
      checks++; if (wr_addr !== 16'h0000) begin errors++; $display("FAIL reset_wr_addr: got %h want 0000", wr_addr); end
      checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
      checks++; if (dut.ptr !== 16'h0000) begin errors++; $display("FAIL reset_ptr: got %h want 0000", dut.ptr); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
      local_wr(8'h00, 8'h5A);
      local_wr(8'h10, 8'h66);
      local_wr(8'h11, 8'h77);
   endtask

   task automatic test_write();
      int acks;
      logic a0, a1, o;
      clr_mon();
      i2c_start();
      send_byte(8'h52, 1'b0, a0, o);
      checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL wr_dev_ack: got %b want 1", a0); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
      acks = 0;
      send_byte(8'h00, 1'b0, a1, o); acks += int'(a1);
      send_byte(8'h10, 1'b0, a1, o); acks += int'(a1);
      send_byte(8'hAB, 1'b0, a1, o); acks += int'(a1);
      send_byte(8'hCD, 1'b0, a1, o); acks += int'(a1);
      i2c_stop();
      checks++; if (acks != 4) begin errors++; $display("FAIL wr_data_acks: got %0d want 4", acks); end
      checks++; if (wr_cnt != 2) begin errors++; $display("FAIL wr_strobes: got %0d want 2", wr_cnt); end
      checks++; if (wa_q[0] !== 16'h0010) begin errors++; $display("FAIL wr_addr0: got %h want 0010", wa_q[0]); end
      checks++; if (wa_q[1] !== (AUTOINC ? 16'h0011 : 16'h0010)) begin errors++; $display("FAIL wr_addr1: got %h want %h", wa_q[1], AUTOINC ? 16'h0011 : 16'h0010); end
      checks++; if (wd_q[0] !== 8'hAB) begin errors++; $display("FAIL wr_data0: got %h want ab", wd_q[0]); end
      checks++; if (wd_q[1] !== 8'hCD) begin errors++; $display("FAIL wr_data1: got %h want cd", wd_q[1]); end
      checks++; if (dut.regfile[8'h10] !== (AUTOINC ? 8'hAB : 8'hCD)) begin errors++; $display("FAIL wr_reg10: got %h want %h", dut.regfile[8'h10], AUTOINC ? 8'hAB : 8'hCD); end
      checks++; if (dut.regfile[8'h11] !== (AUTOINC ? 8'hCD : 8'h77)) begin errors++; $display("FAIL wr_reg11: got %h want %h", dut.regfile[8'h11], AUTOINC ? 8'hCD : 8'h77); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
   endtask

   task automatic test_read();
      int acks;
      logic a, o;
      logic [7:0] d0, d1;
      clr_mon();
      wr_hdr(16'h0010, acks);
      i2c_start();
      send_byte(8'h53, 1'b0, a, o); acks += int'(a);
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      wq();
      checks++; if (acks != 4) begin errors++; $display("FAIL rd_acks: got %0d want 4", acks); end
      checks++; if (d0 !== (AUTOINC ? 8'hAB : 8'hCD)) begin errors++; $display("FAIL rd_byte0: got %h want %h", d0, AUTOINC ? 8'hAB : 8'hCD); end
      checks++; if (d1 !== 8'hCD) begin errors++; $display("FAIL rd_byte1: got %h want cd", d1); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release: got %b want 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_nack: got %b want 0", busy); end
      checks++; if (rd_cnt != 2) begin errors++; $display("FAIL rd_strobes: got %0d want 2", rd_cnt); end
      i2c_stop();
   endtask

   task automatic test_addr_nack();
      logic a, o;
      clr_mon();
      i2c_start();
      send_byte(8'h54, 1'b0, a, o);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL nack_bus: got ack %b want 0", a); end
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL nack_oe9: got %b want 0", o); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b want 0", busy); end
      send_byte(8'h00, 1'b0, a, o);
      checks++; if (dut.state !== ST_WAIT_STOP) begin errors++; $display("FAIL nack_state: got %0d want WAIT_STOP", dut.state); end
      i2c_stop();
      checks++; if (wr_cnt + rd_cnt != 0) begin errors++; $display("FAIL nack_strobes: got %0d want 0", wr_cnt + rd_cnt); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL nack_idle: got %0d want IDLE", dut.state); end
   endtask

   task automatic test_wrap();
      int acks;
      logic a, o;
      clr_mon();
      wr_hdr(16'h00FF, acks);
      send_byte(8'h3C, 1'b0, a, o);
      send_byte(8'hC3, 1'b0, a, o);
      i2c_stop();
      checks++; if (dut.regfile[8'hFF] !== (AUTOINC ? 8'h3C : 8'hC3)) begin errors++; $display("FAIL wrap_regff: got %h want %h", dut.regfile[8'hFF], AUTOINC ? 8'h3C : 8'hC3); end
      checks++; if (dut.regfile[8'h00] !== (AUTOINC ? 8'hC3 : 8'h5A)) begin errors++; $display("FAIL wrap_reg00: got %h want %h", dut.regfile[8'h00], AUTOINC ? 8'hC3 : 8'h5A); end
      checks++; if (wa_q[1] !== (AUTOINC ? 16'h0100 : 16'h00FF)) begin errors++; $display("FAIL wrap_addr1: got %h want %h", wa_q[1], AUTOINC ? 16'h0100 : 16'h00FF); end
      clr_mon();
      wr_hdr(16'hFFFF, acks);
      send_byte(8'h11, 1'b0, a, o);
      send_byte(8'h22, 1'b0, a, o);
      i2c_stop();
      checks++; if (wa_q[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap16_addr0: got %h want ffff", wa_q[0]); end
      checks++; if (wa_q[1] !== (AUTOINC ? 16'h0000 : 16'hFFFF)) begin errors++; $display("FAIL wrap16_addr1: got %h want %h", wa_q[1], AUTOINC ? 16'h0000 : 16'hFFFF); end
      checks++; if (dut.ptr !== (AUTOINC ? 16'h0001 : 16'hFFFF)) begin errors++; $display("FAIL wrap16_ptr: got %h want %h", dut.ptr, AUTOINC ? 16'h0001 : 16'hFFFF); end
   endtask

   task automatic test_stop_partial();
      int acks;
      logic a, o;
      clr_mon();
      wr_hdr(16'h0020, acks);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      checks++; if (wr_cnt != 0) begin errors++; $display("FAIL part_strobes: got %0d want 0", wr_cnt); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL part_state: got %0d want IDLE", dut.state); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL part_busy: got %b want 0", busy); end
      wr_hdr(16'h0020, acks);
      send_byte(8'h99, 1'b0, a, o); acks += int'(a);
      i2c_stop();
      checks++; if (acks != 4) begin errors++; $display("FAIL part_next_acks: got %0d want 4", acks); end
      checks++; if (wr_cnt != 1) begin errors++; $display("FAIL part_next_strobes: got %0d want 1", wr_cnt); end
      checks++; if (dut.regfile[8'h20] !== 8'h99) begin errors++; $display("FAIL part_next_reg: got %h want 99", dut.regfile[8'h20]); end
   endtask

   task automatic test_collision();
      int acks;
      logic a, o;
      clr_mon();
      lw_addr = 8'h30;
      lw_data = 8'hEE;
      wr_hdr(16'h0030, acks);
      send_byte(8'h42, 1'b1, a, o);
      i2c_stop();
      checks++; if (dut.regfile[8'h30] !== 8'h42) begin errors++; $display("FAIL collide_reg: got %h want 42", dut.regfile[8'h30]); end
      checks++; if (wr_cnt != 1) begin errors++; $display("FAIL collide_strobes: got %0d want 1", wr_cnt); end
      local_wr(8'h31, 8'h13);
      checks++; if (dut.regfile[8'h31] !== 8'h13) begin errors++; $display("FAIL local_wr: got %h want 13", dut.regfile[8'h31]); end
   endtask

   task automatic test_reset_mid();
      logic a, o;
      logic [7:0] d;
      logic [7:0] dev;
      local_wr(8'h00, 8'h5A);
      i2c_start();
      dev = 8'h52;
      for (int i = 7; i >= 0; i--) send_bit(dev[i]);
      wq();
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL mid_ack_driven: got %b want 1", sda_oe); end
      #2 reset = 1'b1;
      #1;
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_reset_release: got %b want 0", sda_oe); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      wq(); sda_m = 1'b1; wq(); scl = 1'b1; wq();
      checks++; if (dut.ptr !== 16'h0000) begin errors++; $display("FAIL mid_ptr: got %h want 0000", dut.ptr); end
      i2c_start();
      send_byte(8'h53, 1'b0, a, o);
      read_byte(1'b0, d);
      i2c_stop();
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL mid_dev_ack: got %b want 1", a); end
      checks++; if (d !== 8'h5A) begin errors++; $display("FAIL mid_read0: got %h want 5a", d); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_addr_nack();
      test_wrap();
      test_stop_partial();
      test_collision();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
